// File: rtl/compute_write_addsub_lanes_if.sv
// compute_write_addsub_lanes_if: control, coefficient RAM, operand and write-FIFO stream signals
interface compute_write_addsub_lanes_if #(
  parameter int LANES  = 2,
  parameter int COEF_W = 23,
  parameter int LANE_W = 32,
  parameter int ADDR_W = 8
);
  logic                      start;
  logic [1:0]                mode;
  logic                      busy;
  logic                      done;
  logic [LANES-1:0]          coef_en;
  logic [LANES*ADDR_W-1:0]   coef_addr;
  logic [LANES*COEF_W-1:0]   coef_dout;
  logic                      s_tvalid;
  logic [LANES*COEF_W-1:0]   s_tdata;
  logic                      s_tready;
  logic                      m_tvalid;
  logic [LANES*LANE_W-1:0]   m_tdata;
  logic                      m_tready;
  modport master (
    output start, mode, coef_dout, s_tvalid, s_tdata, m_tready,
    input  busy, done, coef_en, coef_addr, s_tready, m_tvalid, m_tdata
  );
  modport slave (
    input  start, mode, coef_dout, s_tvalid, s_tdata, m_tready,
    output busy, done, coef_en, coef_addr, s_tready, m_tvalid, m_tdata
  );
endinterface

// File: rtl/compute_write_addsub_lanes.sv
// compute_write_addsub_lanes: lane-wise modular add/sub of RAM coefficients with a stream operand into a credit-throttled FWFT FIFO
module compute_write_addsub_lanes #(
  parameter int LANES      = 2,
  parameter int COEF_W     = 23,
  parameter int LANE_W     = 32,
  parameter int N          = 256,
  parameter int ADDR_W     = 8,
  parameter int Q          = 8380417,
  parameter int RAM_LAT    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic rst,
  compute_write_addsub_lanes_if.slave bus
);
  localparam int BEATS = N / LANES;
  localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int PW    = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int IW    = $clog2(RAM_LAT + 2);
  localparam int DW    = LANES * LANE_W;
  localparam logic [COEF_W:0] QX = (COEF_W+1)'(Q);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                  r_state;
  logic [1:0]              r_mode;
  logic [BW-1:0]           r_beat;
  logic                    r_done;
  logic [RAM_LAT-1:0]      r_vld;
  logic [LANES*COEF_W-1:0] r_din [RAM_LAT];
  logic                    r_res_v;
  logic [DW-1:0]           r_res;
  logic [DW-1:0]           r_mem [FIFO_DEPTH];
  logic [PW-1:0]           r_wp, r_rp;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_infl;
  logic                    w_hs, w_pop, w_last_beat;
  logic [DW-1:0]           w_res;
  logic [COEF_W-1:0]       w_c, w_x, w_a, w_b;
  logic [COEF_W:0]         w_s, w_d, w_r;
  // credits: everything accepted but not yet popped must fit in the FIFO
  assign bus.s_tready = (r_state == RUN) && (32'(r_cnt) + 32'(r_infl) < FIFO_DEPTH);
  assign w_hs         = bus.s_tvalid & bus.s_tready;
  assign w_pop        = bus.m_tvalid & bus.m_tready;
  assign w_last_beat  = r_beat == BW'(BEATS - 1);
  assign bus.busy     = r_state != IDLE;
  assign bus.done     = r_done;
  assign bus.coef_en  = {LANES{w_hs}};
  assign bus.m_tvalid = r_cnt != '0;
  assign bus.m_tdata  = bus.m_tvalid ? r_mem[r_rp] : '0;
  always_comb begin
    bus.coef_addr = '0;
    w_res = '0;
    w_c = '0;
    w_x = '0;
    w_a = '0;
    w_b = '0;
    w_s = '0;
    w_d = '0;
    w_r = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.coef_addr[i*ADDR_W +: ADDR_W] = w_hs ? ADDR_W'(32'(r_beat) * LANES + i) : '0;
      w_c = bus.coef_dout[i*COEF_W +: COEF_W];
      w_x = r_din[RAM_LAT-1][i*COEF_W +: COEF_W];
      w_a = r_mode == 2'b10 ? w_x : w_c;
      w_b = r_mode == 2'b10 ? w_c : w_x;
      w_s = {1'b0, w_a} + {1'b0, w_b};
      w_d = {1'b0, w_a} - {1'b0, w_b};
      w_r = (r_mode == 2'b01 || r_mode == 2'b10) ? (w_d[COEF_W] ? w_d + QX : w_d)
                                                 : (w_s >= QX ? w_s - QX : w_s);
      w_res[i*LANE_W +: LANE_W] = LANE_W'(w_r[COEF_W-1:0]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= '0;
      r_beat  <= '0;
      r_done  <= 1'b0;
      r_vld   <= '0;
      r_res_v <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_infl  <= '0;
    end else begin
      r_done  <= 1'b0;
      r_vld   <= RAM_LAT'({r_vld, w_hs});
      r_res_v <= r_vld[RAM_LAT-1];
      r_infl  <= r_infl + IW'(w_hs) - IW'(r_res_v);
      r_cnt   <= r_cnt + CW'(r_res_v) - CW'(w_pop);
      if (r_res_v) r_wp <= r_wp == PW'(FIFO_DEPTH - 1) ? '0 : r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp == PW'(FIFO_DEPTH - 1) ? '0 : r_rp + 1'b1;
      if (w_hs && !w_last_beat) r_beat <= r_beat + 1'b1;
      case (r_state)
        IDLE: if (bus.start) begin
          r_state <= RUN;
          r_mode  <= bus.mode;
          r_beat  <= '0;
        end
        RUN: if (w_hs && w_last_beat) r_state <= DRAIN;
        DRAIN: if (w_pop && r_cnt == CW'(1) && r_infl == '0) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    r_din[0] <= bus.s_tdata;
    for (int j = 1; j < RAM_LAT; j++) r_din[j] <= r_din[j-1];
    r_res <= w_res;
    if (r_res_v) r_mem[r_wp] <= r_res;
  end
endmodule

// File: tb/tb_compute_write_addsub_lanes.sv
// tb_compute_write_addsub_lanes: directed runs of the lane add/sub stage against a small reference
module tb_compute_write_addsub_lanes;
  localparam int L = 2, CW = 23, LW = 32, AW = 8, NN = 256, QQ = 8380417, BEATS = 128, FD = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   coef_cst = 1'b0;
  int   total = 0, bad = 0;
  always #5 clk = ~clk;
  compute_write_addsub_lanes_if #(.LANES(L), .COEF_W(CW), .LANE_W(LW), .ADDR_W(AW)) bus ();
  compute_write_addsub_lanes_if #(.LANES(4), .COEF_W(CW), .LANE_W(LW), .ADDR_W(AW)) bus4 ();
  compute_write_addsub_lanes u_dut (.clk(clk), .rst(rst), .bus(bus));
  compute_write_addsub_lanes #(.LANES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  logic [L*CW-1:0] p1, p2;
  logic [4*CW-1:0] q1, q2;
  function automatic int coef_val(int j);
    return coef_cst ? 5 : j;
  endfunction
  always_ff @(posedge clk) begin
    for (int i = 0; i < L; i++) p1[i*CW +: CW] <= CW'(coef_val(int'(bus.coef_addr[i*AW +: AW])));
    p2 <= p1;
    for (int i = 0; i < 4; i++) q1[i*CW +: CW] <= CW'(bus4.coef_addr[i*AW +: AW]);
    q2 <= q1;
  end
  assign bus.coef_dout  = p2;
  assign bus4.coef_dout = q2;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int modop(logic [1:0] md, int c, int d);
    if (md == 2'b01) return (c - d + QQ) % QQ;
    if (md == 2'b10) return (d - c + QQ) % QQ;
    return (c + d) % QQ;
  endfunction
  function automatic int din_of(int dk, int dval, int k, int i);
    return dk == 0 ? dval : (k * 7919 + i * 131071 + 3) % QQ;
  endfunction
  function automatic logic [L*LW-1:0] exp_beat(logic [1:0] md, bit cst, int dk, int dval, int k);
    logic [L*LW-1:0] e;
    for (int i = 0; i < L; i++)
      e[i*LW +: LW] = 32'(modop(md, cst ? 5 : k * L + i, din_of(dk, dval, k, i)));
    return e;
  endfunction
  function automatic logic [L*AW-1:0] exp_addr(int k);
    logic [L*AW-1:0] a;
    for (int i = 0; i < L; i++) a[i*AW +: AW] = AW'(k * L + i);
    return a;
  endfunction
  task automatic run(input logic [1:0] md, input bit cst, input int dk, input int dval,
                     input int slo, input int shi, input int abort);
    int sent = 0, rcv = 0, cyc = 0, fhs = -1, fv = -1, lp = -1;
    bit pst = 1'b0, fin = 1'b0;
    logic [L*LW-1:0] pd = '0;
    coef_cst = cst;
    bus.start = 1'b1;
    bus.mode = md;
    bus.s_tvalid = 1'b0;
    bus.m_tready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode = md + 2'd1;
    while (!fin && cyc < 3000) begin
      bus.m_tready = !(cyc >= slo && cyc <= shi);
      bus.s_tvalid = 1'b1;
      for (int i = 0; i < L; i++) bus.s_tdata[i*CW +: CW] = CW'(din_of(dk, dval, sent, i));
      bus.start = cyc == 20;
      if (abort > 0 && sent == abort) begin
        rst = 1'b1;
        break;
      end
      #1;
      chk("s_tready", bus.s_tready, sent < BEATS && sent - rcv < FD);
      chk("coef_en", bus.coef_en, (bus.s_tvalid && bus.s_tready) ? 2'b11 : 2'b00);
      if (bus.s_tvalid && bus.s_tready) begin
        chk("coef_addr", bus.coef_addr, exp_addr(sent));
        if (fhs < 0) fhs = cyc;
        sent++;
      end
      if (pst) begin
        chk("hold_valid", bus.m_tvalid, 1);
        chk("hold_data", bus.m_tdata, pd);
      end
      if (bus.m_tvalid && fv < 0) begin
        fv = cyc;
        chk("latency", cyc - fhs, 4);
      end
      if (bus.m_tvalid && bus.m_tready) begin
        chk("beat_index", rcv < BEATS, 1);
        chk("m_tdata", bus.m_tdata, exp_beat(md, cst, dk, dval, rcv));
        rcv++;
        if (rcv == BEATS) lp = cyc;
      end
      chk("done", bus.done, lp >= 0 && cyc == lp + 1);
      chk("busy", bus.busy, !(lp >= 0 && cyc > lp));
      pst = bus.m_tvalid && !bus.m_tready;
      pd = bus.m_tdata;
      fin = bus.done;
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (abort == 0) begin
      chk("beats", rcv, BEATS);
      chk("finished", fin, 1);
    end
  endtask
  task automatic run4();
    int sent = 0, rcv = 0, cyc = 0;
    bit fin = 1'b0;
    logic [127:0] e;
    logic [31:0] a;
    bus4.start = 1'b1;
    bus4.mode = 2'b00;
    bus4.s_tvalid = 1'b0;
    bus4.m_tready = 1'b1;
    bus4.s_tdata = {4{23'(QQ - 1)}};
    @(negedge clk);
    bus4.start = 1'b0;
    while (!fin && cyc < 1000) begin
      bus4.s_tvalid = 1'b1;
      #1;
      if (bus4.s_tvalid && bus4.s_tready) begin
        for (int i = 0; i < 4; i++) a[i*8 +: 8] = 8'(sent * 4 + i);
        chk("l4_addr", bus4.coef_addr, a);
        sent++;
      end
      if (bus4.m_tvalid && bus4.m_tready) begin
        for (int i = 0; i < 4; i++) e[i*32 +: 32] = 32'(modop(2'b00, rcv * 4 + i, QQ - 1));
        chk("l4_data", bus4.m_tdata, e);
        chk("l4_upper", {bus4.m_tdata[127:119], bus4.m_tdata[95:87], bus4.m_tdata[63:55], bus4.m_tdata[31:23]}, 0);
        rcv++;
      end
      fin = bus4.done;
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("l4_sent", sent, 64);
    chk("l4_beats", rcv, 64);
    chk("l4_finished", fin, 1);
  endtask
  initial begin
    bus4.start = 1'b0;
    bus4.mode = 2'b00;
    bus4.s_tvalid = 1'b0;
    bus4.s_tdata = '0;
    bus4.m_tready = 1'b1;
    rst = 1'b1;
    repeat (3) begin
      bus.start = 1'($urandom);
      bus.mode = 2'($urandom);
      bus.s_tvalid = 1'($urandom);
      bus.s_tdata = 46'({$urandom, $urandom});
      bus.m_tready = 1'($urandom);
      @(negedge clk);
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_coef_en", bus.coef_en, 0);
      chk("rst_coef_addr", bus.coef_addr, 0);
      chk("rst_s_tready", bus.s_tready, 0);
      chk("rst_m_tvalid", bus.m_tvalid, 0);
      chk("rst_m_tdata", bus.m_tdata, 0);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    bus.s_tvalid = 1'b0;
    bus.m_tready = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_s_tready", bus.s_tready, 0);
    run(2'b00, 1'b0, 0, QQ - 1, -1, -1, 0);
    run(2'b01, 1'b1, 0, 7, -1, -1, 0);
    run(2'b10, 1'b1, 0, 7, -1, -1, 0);
    run(2'b11, 1'b0, 0, QQ - 1, -1, -1, 0);
    run(2'b00, 1'b0, 0, QQ - 1, 10, 40, 0);
    run(2'b10, 1'b0, 1, 0, 5, 12, 0);
    run(2'b00, 1'b0, 0, QQ - 1, -1, -1, 50);
    repeat (2) @(negedge clk);
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_m_tvalid", bus.m_tvalid, 0);
    chk("abort_s_tready", bus.s_tready, 0);
    chk("abort_coef_en", bus.coef_en, 0);
    chk("abort_m_tdata", bus.m_tdata, 0);
    rst = 1'b0;
    bus.start = 1'b0;
    bus.s_tvalid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("abort_no_done", bus.done, 0);
      chk("abort_idle", bus.busy, 0);
    end
    run(2'b01, 1'b0, 1, 0, 30, 33, 0);
    run4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
